vga_frame_sequencer: RTL and testbench

Video timing and animation scheduler for the nyancat renderer. Generates the raster position, sync and blanking signals that sequence the pixel datapath, plus per-line and per-frame strobes and a slow animation-frame index that advances every ANIM_DIV frames. Sits inside the TinyTapeout user module, clocked by the same divided pixel clock (24 MHz on the OrangeCrab board) that drives the rest of the renderer.

---
 rtl/vga_frame_sequencer.sv | 147 ++++++++++++++
 tb/tb_vga_frame_sequencer.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_frame_sequencer.sv
// VGA raster timing generator with line/frame strobes and a frame-divided animation index.
// Every output is a flop whose next value is decoded from the next-state position counters.
module vga_frame_sequencer #(
   parameter int H_ACTIVE    = 640,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_ACTIVE    = 480,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter int SYNC_ACTIVE = 0,
   parameter int ANIM_DIV    = 6,
   parameter int ANIM_FRAMES = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   output logic [9:0] hpos,
   output logic [9:0] vpos,
   output logic       display_on,
   output logic       hsync,
   output logic       vsync,
   output logic       line_start,
   output logic       frame_start,
   output logic       anim_tick,
   output logic [3:0] anim_frame
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DIV_W   = $clog2(ANIM_DIV + 1);

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS   = 10'(H_ACTIVE);
   localparam logic [9:0] V_VIS   = 10'(V_ACTIVE);
   localparam logic [9:0] HS_BEG  = 10'(H_ACTIVE + H_FP);
   localparam logic [9:0] HS_END  = 10'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0] VS_BEG  = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0] VS_END  = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic       SYNC_ON = 1'(SYNC_ACTIVE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ANIM_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
   localparam logic [3:0]       AF_LAST  = 4'(ANIM_FRAMES - 1);

   logic [9:0]       h_q, h_d;
   logic [9:0]       v_q, v_d;
   logic             disp_q, disp_d;
   logic             hs_q, hs_d;
   logic             vs_q, vs_d;
   logic             ls_q, ls_d;
   logic             fs_q, fs_d;
   logic             at_q, at_d;
   logic [3:0]       af_q, af_d;
   logic [DIV_W-1:0] div_q, div_d;

   // Position counters, strobes and the animation divider advance only on enabled cycles.
   always_comb begin
      h_d   = h_q;
      v_d   = v_q;
      div_d = div_q;
      af_d  = af_q;
      ls_d  = 1'b0;
      fs_d  = 1'b0;
      at_d  = 1'b0;
      if (ena) begin
         if (h_q == H_LAST) begin
            h_d = 10'd0;
            if (v_q == V_LAST) begin
               v_d = 10'd0;
            end else begin
               v_d = v_q + 10'd1;
            end
         end else begin
            h_d = h_q + 10'd1;
         end
         ls_d = (h_d == 10'd0);
         fs_d = (h_d == 10'd0) && (v_d == 10'd0);
         if (fs_d) begin
            if (div_q == DIV_LAST) begin
               div_d = DIV_ZERO;
               at_d  = 1'b1;
               if (af_q == AF_LAST) begin
                  af_d = 4'd0;
               end else begin
                  af_d = af_q + 4'd1;
               end
            end else begin
               div_d = div_q + DIV_ONE;
            end
         end else begin
            div_d = div_q;
         end
      end else begin
         h_d = h_q;
         v_d = v_q;
      end
   end

   // Levels decoded from next-state position; with ena low h_d/v_d equal the held values.
   always_comb begin
      disp_d = (h_d < H_VIS) && (v_d < V_VIS);
      hs_d   = ((h_d >= HS_BEG) && (h_d < HS_END)) ? SYNC_ON : ~SYNC_ON;
      vs_d   = ((v_d >= VS_BEG) && (v_d < VS_END)) ? SYNC_ON : ~SYNC_ON;
   end

   // State registers, reset to the last pixel of the last line so the first enabled edge opens a frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_q    <= H_LAST;
         v_q    <= V_LAST;
         disp_q <= 1'b0;
         hs_q   <= ~SYNC_ON;
         vs_q   <= ~SYNC_ON;
         ls_q   <= 1'b0;
         fs_q   <= 1'b0;
         at_q   <= 1'b0;
         af_q   <= 4'd0;
         div_q  <= DIV_ZERO;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         disp_q <= disp_d;
         hs_q   <= hs_d;
         vs_q   <= vs_d;
         ls_q   <= ls_d;
         fs_q   <= fs_d;
         at_q   <= at_d;
         af_q   <= af_d;
         div_q  <= div_d;
      end
   end

   assign hpos        = h_q;
   assign vpos        = v_q;
   assign display_on  = disp_q;
   assign hsync       = hs_q;
   assign vsync       = vs_q;
   assign line_start  = ls_q;
   assign frame_start = fs_q;
   assign anim_tick   = at_q;
   assign anim_frame  = af_q;

endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Scoreboard bench for vga_frame_sequencer on a shrunken raster; expectations come from an
// enabled-cycle count converted to position/animation state with plain arithmetic.
module tb_vga_frame_sequencer;

   localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
   localparam int VA = 6, VFP = 1, VS = 2, VBP = 1;
   localparam int SA = 0, AD = 3, AF = 4;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;
   localparam int FRAME = HT * VT;

   typedef struct packed {
      logic [9:0] h;
      logic [9:0] v;
      logic       disp;
      logic       hs;
      logic       vs;
      logic       ls;
      logic       fs;
      logic       at;
      logic [3:0] af;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic [9:0] hpos, vpos;
   logic       display_on, hsync, vsync, line_start, frame_start, anim_tick;
   logic [3:0] anim_frame;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   stim_done = 1'b0;

   // model state: enabled cycles since reset (0 = still at reset position)
   longint t = 0;

   vga_frame_sequencer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .SYNC_ACTIVE(SA), .ANIM_DIV(AD), .ANIM_FRAMES(AF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .hpos(hpos), .vpos(vpos), .display_on(display_on),
      .hsync(hsync), .vsync(vsync), .line_start(line_start),
      .frame_start(frame_start), .anim_tick(anim_tick), .anim_frame(anim_frame)
   );

   always #5 clk = ~clk;

   function automatic exp_t model(input longint tc, input bit en_now);
      exp_t   e;
      longint p, nfs;
      logic   son;
      son = 1'(SA);
      if (tc == 0) begin
         e.h = 10'(HT - 1); e.v = 10'(VT - 1); e.disp = 1'b0;
         e.hs = ~son; e.vs = ~son; e.ls = 1'b0; e.fs = 1'b0; e.at = 1'b0; e.af = 4'd0;
      end else begin
         p     = (tc - 1) % FRAME;
         nfs   = (tc - 1) / FRAME + 1;
         e.h   = 10'(p % HT);
         e.v   = 10'(p / HT);
         e.disp = (int'(e.h) < HA) && (int'(e.v) < VA);
         e.hs  = (int'(e.h) >= HA + HFP && int'(e.h) < HA + HFP + HS) ? son : ~son;
         e.vs  = (int'(e.v) >= VA + VFP && int'(e.v) < VA + VFP + VS) ? son : ~son;
         e.ls  = en_now && (e.h == 10'd0);
         e.fs  = en_now && (p == 0);
         e.at  = e.fs && (nfs % AD == 0);
         e.af  = 4'((nfs / AD) % AF);
      end
      return e;
   endfunction

   // One stimulus step: drive at negedge, advance model, queue expectation for the next edge.
   task automatic step(input bit rst_v, input bit ena_v);
      bit en_now;
      @(negedge clk);
      rst_n = ~rst_v;
      ena   = ena_v;
      en_now = 1'b0;
      if (rst_v) begin
         t = 0;
      end else if (ena_v) begin
         t++;
         en_now = 1'b1;
      end
      q.push_back(model(t, en_now));
   endtask

   initial begin : stim
      int cnt;
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 14 * FRAME + 5; i++) step(1'b0, 1'b1);
      for (int i = 0; i < 3000; i++) step(1'b0, ($urandom_range(0, 9) < 7));
      // gap of 50 disabled cycles right after a line start
      cnt = 0;
      while (((t - 1) % HT) != 0 && cnt < 2 * HT) begin
         step(1'b0, 1'b1);
         cnt++;
      end
      for (int i = 0; i < 50; i++) step(1'b0, 1'b0);
      for (int i = 0; i < FRAME + 3; i++) step(1'b0, 1'b1);
      // mid-frame reset with anim_frame non-zero
      cnt = 0;
      while (!((((t - 1) % FRAME) / HT == VT / 2) && (((t - 1) / FRAME + 1) / AD) % AF == 2)
             && cnt < 20 * FRAME) begin
         step(1'b0, 1'b1);
         cnt++;
      end
      for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
      step(1'b0, 1'b0);
      for (int i = 0; i < 4 * FRAME; i++) step(1'b0, ($urandom_range(0, 3) != 0));
      @(negedge clk);
      stim_done = 1'b1;
   end

   initial begin : mon
      exp_t e, a;
      int   idle;
      idle = 0;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            a = '{hpos, vpos, display_on, hsync, vsync, line_start, frame_start, anim_tick, anim_frame};
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL cycle_out t=%0t got h=%0d v=%0d disp=%b hs=%b vs=%b ls=%b fs=%b at=%b af=%0d want h=%0d v=%0d disp=%b hs=%b vs=%b ls=%b fs=%b at=%b af=%0d",
                        $time, a.h, a.v, a.disp, a.hs, a.vs, a.ls, a.fs, a.at, a.af,
                        e.h, e.v, e.disp, e.hs, e.vs, e.ls, e.fs, e.at, e.af);
            end
         end else if (stim_done) begin
            break;
         end
      end
   end

   initial begin : watchdog
      #(20 * 90000);
      errors++;
      $display("FAIL watchdog time limit reached, got no completion, want completion");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end

   initial begin : finish_blk
      wait (stim_done);
      repeat (3) @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain got %0d pending, want 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
